// File: rtl/match_scan_ctrl.sv
// Lookup sequencer: walks a DEPTH-entry {vld,key} table one entry per cycle
// through a single shared equality comparator and reports the first match.
module match_scan_ctrl #(
  parameter int unsigned KEY_W = 2,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [KEY_W-1:0] wr_key,
  input  logic             wr_vld,
  input  logic             tbl_clr,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [KEY_W-1:0] req_key,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_hit,
  output logic [IDX_W-1:0] rsp_idx,
  output logic             busy,
  output logic [7:0]       hit_cnt
);

  localparam int unsigned CNT_W = 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e                      state_q, state_d;
  logic [DEPTH-1:0][KEY_W-1:0] tbl_key_q, tbl_key_d;
  logic [DEPTH-1:0]            tbl_vld_q, tbl_vld_d;
  logic [KEY_W-1:0]            key_q, key_d;
  logic [IDX_W-1:0]            scan_idx_q, scan_idx_d;
  logic                        rsp_hit_q, rsp_hit_d;
  logic [IDX_W-1:0]            rsp_idx_q, rsp_idx_d;
  logic [CNT_W-1:0]            hit_cnt_q, hit_cnt_d;
  logic                        req_ready_q, req_ready_d;
  logic                        rsp_valid_q, rsp_valid_d;
  logic                        busy_q, busy_d;
  logic                        eq_c, match_c;

  // Table update: a write to wr_idx takes priority over a same-cycle clear
  always_comb begin
    tbl_key_d = tbl_key_q;
    tbl_vld_d = tbl_vld_q;
    if (tbl_clr) begin
      tbl_vld_d = '0;
    end
    if (wr_en) begin
      tbl_key_d[wr_idx] = wr_key;
      tbl_vld_d[wr_idx] = wr_vld;
    end
  end

  // Shared comparator sees only the registered table contents
  assign eq_c    = &(~(key_q ^ tbl_key_q[scan_idx_q]));
  assign match_c = eq_c & tbl_vld_q[scan_idx_q];

  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    scan_idx_d = scan_idx_q;
    rsp_hit_d  = rsp_hit_q;
    rsp_idx_d  = rsp_idx_q;
    hit_cnt_d  = hit_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          key_d      = req_key;
          scan_idx_d = '0;
          state_d    = S_SCAN;
        end
      end
      S_SCAN: begin
        if (match_c) begin
          rsp_hit_d = 1'b1;
          rsp_idx_d = scan_idx_q;
          state_d   = S_RESP;
        end else if (scan_idx_q == LAST_IDX) begin
          rsp_hit_d = 1'b0;
          rsp_idx_d = '0;
          state_d   = S_RESP;
        end else begin
          scan_idx_d = scan_idx_q + IDX_W'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          if (rsp_hit_q && (hit_cnt_q != CNT_MAX)) begin
            hit_cnt_d = hit_cnt_q + CNT_W'(1);
          end
          rsp_hit_d = 1'b0;
          rsp_idx_d = '0;
          state_d   = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    req_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      tbl_key_q   <= '0;
      tbl_vld_q   <= '0;
      key_q       <= '0;
      scan_idx_q  <= '0;
      rsp_hit_q   <= 1'b0;
      rsp_idx_q   <= '0;
      hit_cnt_q   <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tbl_key_q   <= tbl_key_d;
      tbl_vld_q   <= tbl_vld_d;
      key_q       <= key_d;
      scan_idx_q  <= scan_idx_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_idx_q   <= rsp_idx_d;
      hit_cnt_q   <= hit_cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_hit   = rsp_hit_q;
  assign rsp_idx   = rsp_idx_q;
  assign busy      = busy_q;
  assign hit_cnt   = hit_cnt_q;

endmodule
